// File: rtl/bcd_enc_stream_pkg.sv
// Shared types and constants for the streaming binary-to-BCD encoder.
package bcd_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_HOLD = 2'd2
   } bcd_state_t;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

   // Iteration counter width; never narrower than one bit.
   function automatic int unsigned bcd_cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bcd_enc_stream_if.sv
// Valid/ready handshake bundle between binary producer, encoder and BCD consumer.
interface bcd_enc_stream_if #(
   parameter int LEN    = 8,
   parameter int DIGITS = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [LEN-1:0]        bin;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd;
   logic                  sign;
   logic                  ovfl;

   modport master (
      output in_valid, bin, out_ready,
      input  in_ready, out_valid, bcd, sign, ovfl
   );

   modport slave (
      input  in_valid, bin, out_ready,
      output in_ready, out_valid, bcd, sign, ovfl
   );
endinterface

// File: rtl/bcd_enc_stream_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift left by one.
module bcd_dabble_step
   import bcd_pkg::*;
#(
   parameter int LEN    = 8,
   parameter int DIGITS = 3
) (
   input  logic [4*DIGITS+LEN-1:0] din,
   output logic [4*DIGITS+LEN-1:0] dout,
   output logic                    carry_out
);
   localparam int W = 4*DIGITS+LEN;

   logic [W-1:0] adj;

   always_comb begin
      adj = din;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (adj[LEN+4*d +: 4] >= BCD_ADJ_THRESH)
            adj[LEN+4*d +: 4] = adj[LEN+4*d +: 4] + BCD_ADJ_ADD;
      end
   end

   assign dout      = {adj[W-2:0], 1'b0};
   assign carry_out = adj[W-1];
endmodule

// File: rtl/bcd_enc_stream.sv
// Streaming binary-to-BCD encoder, STEPS dabble iterations per clock.
// Optional macro BCD_ENC_STREAM_SIGNED_EN: two's-complement input with sign output.
module bcd_enc_stream
   import bcd_pkg::*;
#(
   parameter int LEN    = 8,
   parameter int DIGITS = 3,
   parameter int STEPS  = 1
) (
   input  logic              clk,
   input  logic              rst,
   bcd_enc_stream_if.slave   bus
);
   localparam int          W  = 4*DIGITS+LEN;
   localparam int unsigned N  = LEN/STEPS;
   localparam int unsigned CW = bcd_cnt_width(N);

   if (LEN % STEPS != 0) begin : g_bad_steps
      $error("bcd_enc_stream: LEN (%0d) must be a multiple of STEPS (%0d)", LEN, STEPS);
   end
   if (LEN < 2 || DIGITS < 1) begin : g_bad_size
      $error("bcd_enc_stream: LEN must be >= 2 and DIGITS >= 1");
   end

   bcd_state_t      state;
   logic [W-1:0]    work;
   logic [CW-1:0]   cnt;
   logic            ovfl_q;
   logic [LEN-1:0]  mag;
   logic            accept;

   logic [W-1:0]     stage [STEPS+1];
   logic [STEPS-1:0] shout;

   assign stage[0] = work;

   for (genvar i = 0; i < STEPS; i++) begin : g_step
      bcd_dabble_step #(
         .LEN    (LEN),
         .DIGITS (DIGITS)
      ) u_step (
         .din       (stage[i]),
         .dout      (stage[i+1]),
         .carry_out (shout[i])
      );
   end

   assign bus.in_ready = (state == S_IDLE) || ((state == S_HOLD) && bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

`ifdef BCD_ENC_STREAM_SIGNED_EN
   logic sign_q;
   // Magnitude wraps in LEN bits, so the most negative input yields 2^(LEN-1).
   assign mag      = bus.bin[LEN-1] ? (LEN'(0) - bus.bin) : bus.bin;
   assign bus.sign = sign_q;
`else
   assign mag      = bus.bin;
   assign bus.sign = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= S_IDLE;
         work   <= '0;
         cnt    <= '0;
         ovfl_q <= 1'b0;
`ifdef BCD_ENC_STREAM_SIGNED_EN
         sign_q <= 1'b0;
`endif
      end else if (accept) begin
         // Accept covers both idle start and the back-to-back reload from hold.
         state  <= S_CONV;
         work   <= {{(4*DIGITS){1'b0}}, mag};
         cnt    <= '0;
         ovfl_q <= 1'b0;
`ifdef BCD_ENC_STREAM_SIGNED_EN
         sign_q <= bus.bin[LEN-1];
`endif
      end else begin
         case (state)
            S_CONV: begin
               work   <= stage[STEPS];
               ovfl_q <= ovfl_q | (|shout);
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(N-1))
                  state <= S_HOLD;
            end
            S_HOLD: begin
               if (bus.out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.out_valid = (state == S_HOLD);
   assign bus.bcd       = work[W-1:LEN];
   assign bus.ovfl      = ovfl_q;
endmodule

// File: tb/tb_bcd_enc_stream.sv
// Directed bench for bcd_enc_stream: default, DIGITS=2 and STEPS=2 instances side by side.
module tb_bcd_enc_stream;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   bcd_enc_stream_if #(.LEN(8), .DIGITS(3)) if0 ();
   bcd_enc_stream_if #(.LEN(8), .DIGITS(2)) if1 ();
   bcd_enc_stream_if #(.LEN(8), .DIGITS(3)) if2 ();

   bcd_enc_stream #(.LEN(8), .DIGITS(3), .STEPS(1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
   bcd_enc_stream #(.LEN(8), .DIGITS(2), .STEPS(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
   bcd_enc_stream #(.LEN(8), .DIGITS(3), .STEPS(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

`ifdef BCD_ENC_STREAM_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drivers: launch one operand and wait (bounded) for out_valid; lat = cycles after accept edge.
   task automatic conv0(input logic [7:0] b, output int lat);
      if0.bin = b; if0.in_valid = 1'b1;
      tick;
      if0.in_valid = 1'b0;
      lat = 0;
      while (if0.out_valid !== 1'b1 && lat < 40) begin tick; lat++; end
   endtask

   task automatic conv1(input logic [7:0] b, output int lat);
      if1.bin = b; if1.in_valid = 1'b1;
      tick;
      if1.in_valid = 1'b0;
      lat = 0;
      while (if1.out_valid !== 1'b1 && lat < 40) begin tick; lat++; end
   endtask

   task automatic conv2(input logic [7:0] b, output int lat);
      if2.bin = b; if2.in_valid = 1'b1;
      tick;
      if2.in_valid = 1'b0;
      lat = 0;
      while (if2.out_valid !== 1'b1 && lat < 40) begin tick; lat++; end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      if0.in_valid = 1'b0; if0.bin = '0; if0.out_ready = 1'b1;
      if1.in_valid = 1'b0; if1.bin = '0; if1.out_ready = 1'b1;
      if2.in_valid = 1'b0; if2.bin = '0; if2.out_ready = 1'b1;
      tick; tick;
      checks++; if (if0.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", if0.out_valid); else passes++;
      checks++; if (if0.bcd !== 12'h000) $display("FAIL reset_bcd got %h want 000", if0.bcd); else passes++;
      checks++; if (if0.ovfl !== 1'b0) $display("FAIL reset_ovfl got %b want 0", if0.ovfl); else passes++;
      checks++; if (if0.sign !== 1'b0) $display("FAIL reset_sign got %b want 0", if0.sign); else passes++;
      checks++; if (if0.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", if0.in_ready); else passes++;
      checks++; if (if1.in_ready !== 1'b1 || if2.in_ready !== 1'b1)
         $display("FAIL reset_in_ready_other got %b%b want 11", if1.in_ready, if2.in_ready); else passes++;
      rst = 1'b1;
      tick;
   endtask

   task automatic test_basic;
      logic [7:0]  vin  [4];
      logic [11:0] vbcd [4];
      logic        vsgn [4];
      int lat;
`ifdef BCD_ENC_STREAM_SIGNED_EN
      vin = '{8'h80, 8'hFF, 8'h00, 8'h85};
      vbcd = '{12'h128, 12'h001, 12'h000, 12'h123};
      vsgn = '{1'b1, 1'b1, 1'b0, 1'b1};
`else
      vin = '{8'd255, 8'd128, 8'd0, 8'h85};
      vbcd = '{12'h255, 12'h128, 12'h000, 12'h133};
      vsgn = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      if0.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         conv0(vin[i], lat);
         checks++; if (lat != 8) $display("FAIL basic_latency[%0d] got %0d want 8", i, lat); else passes++;
         checks++; if (if0.bcd !== vbcd[i]) $display("FAIL basic_bcd[%0d] got %h want %h", i, if0.bcd, vbcd[i]); else passes++;
         checks++; if (if0.ovfl !== 1'b0) $display("FAIL basic_ovfl[%0d] got %b want 0", i, if0.ovfl); else passes++;
         checks++; if (if0.sign !== vsgn[i]) $display("FAIL basic_sign[%0d] got %b want %b", i, if0.sign, vsgn[i]); else passes++;
         tick;
         checks++; if (if0.out_valid !== 1'b0) $display("FAIL basic_one_pulse[%0d] got %b want 0", i, if0.out_valid); else passes++;
      end
   endtask

   task automatic test_ovfl;
      int lat;
      // Signed build uses -100 for the overflowing case (magnitude 100).
      conv1(SGN ? 8'h9C : 8'd200, lat);
      checks++; if (lat != 8) $display("FAIL ovfl_latency got %0d want 8", lat); else passes++;
      checks++; if (if1.bcd !== 8'h00) $display("FAIL ovfl_bcd got %h want 00", if1.bcd); else passes++;
      checks++; if (if1.ovfl !== 1'b1) $display("FAIL ovfl_flag got %b want 1", if1.ovfl); else passes++;
      checks++; if (if1.sign !== SGN) $display("FAIL ovfl_sign got %b want %b", if1.sign, SGN); else passes++;
      tick;
      conv1(8'd99, lat);
      checks++; if (if1.bcd !== 8'h99) $display("FAIL ovfl99_bcd got %h want 99", if1.bcd); else passes++;
      checks++; if (if1.ovfl !== 1'b0) $display("FAIL ovfl99_flag got %b want 0", if1.ovfl); else passes++;
      checks++; if (if1.sign !== 1'b0) $display("FAIL ovfl99_sign got %b want 0", if1.sign); else passes++;
      tick;
   endtask

   task automatic test_backpressure;
      int lat;
      if0.out_ready = 1'b0;
      conv0(8'd42, lat);
      checks++; if (lat != 8) $display("FAIL bp_latency got %0d want 8", lat); else passes++;
      if0.bin = 8'd99; if0.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (if0.bcd !== 12'h042 || if0.ovfl !== 1'b0 || if0.in_ready !== 1'b0 || if0.out_valid !== 1'b1)
            $display("FAIL bp_hold[%0d] got bcd=%h ovfl=%b in_ready=%b out_valid=%b want 042/0/0/1",
                     i, if0.bcd, if0.ovfl, if0.in_ready, if0.out_valid);
         else passes++;
         tick;
      end
      if0.bin = 8'd7; if0.out_ready = 1'b1;
      #1;
      checks++; if (if0.in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", if0.in_ready); else passes++;
      tick;
      if0.in_valid = 1'b0;
      checks++; if (if0.out_valid !== 1'b0) $display("FAIL bp_reaccept got %b want 0", if0.out_valid); else passes++;
      lat = 0;
      while (if0.out_valid !== 1'b1 && lat < 40) begin tick; lat++; end
      checks++; if (lat != 8) $display("FAIL bp_next_latency got %0d want 8", lat); else passes++;
      checks++; if (if0.bcd !== 12'h007) $display("FAIL bp_next_bcd got %h want 007", if0.bcd); else passes++;
      tick;
   endtask

   task automatic test_steps2;
      int lat;
      if2.out_ready = 1'b1;
      conv2(8'd128, lat);
      checks++; if (lat != 4) $display("FAIL s2_latency got %0d want 4", lat); else passes++;
      checks++; if (if2.bcd !== 12'h128) $display("FAIL s2_bcd got %h want 128", if2.bcd); else passes++;
      checks++; if (if2.sign !== SGN) $display("FAIL s2_sign got %b want %b", if2.sign, SGN); else passes++;
      checks++; if (if2.ovfl !== 1'b0) $display("FAIL s2_ovfl got %b want 0", if2.ovfl); else passes++;
      tick;
   endtask

   task automatic test_back_to_back;
      int lat;
      if2.out_ready = 1'b1;
      if2.bin = 8'd12; if2.in_valid = 1'b1;
      tick;
      if2.bin = 8'd34;
      lat = 0;
      while (if2.out_valid !== 1'b1 && lat < 40) begin tick; lat++; end
      checks++; if (lat != 4) $display("FAIL b2b_first_latency got %0d want 4", lat); else passes++;
      checks++; if (if2.bcd !== 12'h012) $display("FAIL b2b_first_bcd got %h want 012", if2.bcd); else passes++;
      checks++; if (if2.in_ready !== 1'b1) $display("FAIL b2b_hold_ready got %b want 1", if2.in_ready); else passes++;
      tick;
      if2.in_valid = 1'b0;
      lat = 1;
      while (if2.out_valid !== 1'b1 && lat < 40) begin tick; lat++; end
      checks++; if (lat != 5) $display("FAIL b2b_period got %0d want 5", lat); else passes++;
      checks++; if (if2.bcd !== 12'h034) $display("FAIL b2b_second_bcd got %h want 034", if2.bcd); else passes++;
      tick;
   endtask

   task automatic test_reset_mid;
      int seen;
      if0.out_ready = 1'b1;
      if0.bin = 8'd77; if0.in_valid = 1'b1;
      tick;
      if0.in_valid = 1'b0;
      tick; tick;
      rst = 1'b0;
      tick;
      rst = 1'b1;
      checks++; if (if0.in_ready !== 1'b1) $display("FAIL rmid_in_ready got %b want 1", if0.in_ready); else passes++;
      checks++; if (if0.out_valid !== 1'b0) $display("FAIL rmid_out_valid got %b want 0", if0.out_valid); else passes++;
      checks++; if (if0.bcd !== 12'h000) $display("FAIL rmid_bcd got %h want 000", if0.bcd); else passes++;
      seen = 0;
      repeat (20) begin
         tick;
         if (if0.out_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0) $display("FAIL rmid_stale got %0d pulses want 0", seen); else passes++;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_ovfl;
      test_backpressure;
      test_steps2;
      test_back_to_back;
      test_reset_mid;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
